// File: rtl/obstacle_debounce_if.sv
// Signal bundle between the IR sensor stage, the debounce block and the drive controller.
// All signals are plain levels sampled on clk; there is no valid/ready handshake on this bus.
interface obstacle_debounce_if #(
  parameter int CNT_W = 8
);
  logic             obstacle_in;
  logic             enable;
  logic             clear_count;
  logic             stop_req;
  logic             obstacle_det;
  logic             det_pulse;
  logic [CNT_W-1:0] event_count;
  logic [1:0]       state_dbg;

  modport master (
    output obstacle_in, enable, clear_count,
    input  stop_req, obstacle_det, det_pulse, event_count, state_dbg
  );

  modport slave (
    input  obstacle_in, enable, clear_count,
    output stop_req, obstacle_det, det_pulse, event_count, state_dbg
  );
endinterface

// File: rtl/obstacle_debounce.sv
// Synchronizes and debounces the IR obstacle level, holds the stop request through a
// minimum release time, and counts qualified detections with saturation.
module obstacle_debounce #(
  parameter int DEB_CYCLES  = 5000,
  parameter int HOLD_CYCLES = 100000,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  obstacle_debounce_if.slave bus
);
  localparam int MAX_CYC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, BLOCKED, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             sync1_q, sync2_q;
  logic             stop_q, stop_d;
  logic             det_q, det_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            if (DEB_CYCLES == 1) begin
              state_d = BLOCKED;
              tmr_d   = '0;
              pulse_d = 1'b1;
            end else begin
              state_d = QUALIFY;
              tmr_d   = TMR_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (!sync2_q) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == DEB_LAST) begin
            state_d = BLOCKED;
            tmr_d   = '0;
            pulse_d = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        BLOCKED: begin
          if (!sync2_q) begin
            if (HOLD_CYCLES == 1) begin
              state_d = IDLE;
              tmr_d   = '0;
            end else begin
              state_d = RELEASE;
              tmr_d   = TMR_W'(1);
            end
          end
        end
        RELEASE: begin
          // Re-rising during the hold is the same obstacle event: no pulse, no count.
          if (sync2_q) begin
            state_d = BLOCKED;
            tmr_d   = '0;
          end else if (tmr_q == HOLD_LAST) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stop_d = (state_d == BLOCKED) || (state_d == RELEASE);
    det_d  = (state_d == BLOCKED);
    cnt_d  = cnt_q;
    if (bus.clear_count) begin
      cnt_d = pulse_d ? CNT_W'(1) : '0;
    end else if (pulse_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      tmr_q   <= '0;
      stop_q  <= 1'b0;
      det_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus.obstacle_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      stop_q  <= stop_d;
      det_q   <= det_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stop_req     = stop_q;
  assign bus.obstacle_det = det_q;
  assign bus.det_pulse    = pulse_q;
  assign bus.event_count  = cnt_q;
  assign bus.state_dbg    = state_q;
endmodule
